// File: rtl/task_pkt_pkg.sv
// Shared types for the task packet output block: FSM states and the
// width of the packet byte-count output.
package task_pkt_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2
    } state_t;

    localparam int PKT_BYTES_W = 12;

endpackage

// File: rtl/task_pkt_buf.sv
// Simple dual-port packet RAM: synchronous write, one-cycle registered read.
// The read register is the output data register of the parent block, so it resets.
module task_pkt_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 128,
    parameter int AW         = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // rdata only advances on re, which lets it hold a stalled beat
    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/task_pkt_out.sv
// Packet assembler: buffers up to MAX_WORDS input words, then streams the
// packet out with valid/ready handshaking and a registered byte count.
module task_pkt_out
    import task_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WORDS  = 128,
    parameter int CNT_W      = $clog2(MAX_WORDS + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic                   i_data_valid,
    input  logic                   i_input_last,
    input  logic [CNT_W-1:0]       i_pkt_words,
    input  logic                   i_tmanager_ready,
    output logic                   o_tanswer_ready,
    output logic [DATA_WIDTH-1:0]  o_tdata,
    output logic                   o_tanswer_data_last,
    output logic [PKT_BYTES_W-1:0] o_packet_size_in_bytes,
    output logic                   o_busy,
    output logic                   o_full,
    output logic                   o_overflow
);

    localparam int AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [CNT_W-1:0]       MAX_CNT = CNT_W'(MAX_WORDS);
    localparam logic [PKT_BYTES_W-1:0] BPW     = PKT_BYTES_W'(DATA_WIDTH / 8);

    state_t           state;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] rd_idx;

    logic             accept;
    logic             xfer;
    logic             close;
    logic [CNT_W-1:0] tgt_eff;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] rd_nxt;
    logic             ren;
    logic [AW-1:0]    raddr;

    assign accept = i_data_valid && (state != S_SEND);
    assign xfer   = o_tanswer_ready && i_tmanager_ready;
    assign rd_nxt = rd_idx + 1'b1;

    always_comb begin
        tgt_eff = target;
        // the first word of a packet uses the live length input
        if (state == S_IDLE)
            tgt_eff = (i_pkt_words == '0 || i_pkt_words > MAX_CNT) ? MAX_CNT : i_pkt_words;
        cnt_n = accept ? wr_cnt + 1'b1 : wr_cnt;
        close = (state != S_SEND) &&
                ((cnt_n == tgt_eff) || (i_input_last && cnt_n != '0));
        ren   = 1'b0;
        raddr = '0;
        if (state == S_SEND) begin
            if (!o_tanswer_ready) begin
                ren = 1'b1;
            end else if (xfer && !o_tanswer_data_last) begin
                ren   = 1'b1;
                raddr = rd_nxt[AW-1:0];
            end
        end
    end

    task_pkt_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_WORDS),
        .AW         (AW)
    ) u_buf (
        .clk   (i_clk),
        .rst   (i_rst),
        .we    (accept),
        .waddr (wr_cnt[AW-1:0]),
        .wdata (i_data),
        .re    (ren),
        .raddr (raddr),
        .rdata (o_tdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state                  <= S_IDLE;
            wr_cnt                 <= '0;
            target                 <= '0;
            rd_idx                 <= '0;
            o_tanswer_ready        <= 1'b0;
            o_tanswer_data_last    <= 1'b0;
            o_packet_size_in_bytes <= '0;
            o_busy                 <= 1'b0;
            o_full                 <= 1'b0;
            o_overflow             <= 1'b0;
        end else begin
            o_overflow <= (state == S_SEND) && i_data_valid;
            case (state)
                S_IDLE, S_LOAD: begin
                    wr_cnt <= cnt_n;
                    target <= tgt_eff;
                    o_full <= (cnt_n == MAX_CNT);
                    if (close) begin
                        state                  <= S_SEND;
                        o_busy                 <= 1'b1;
                        o_packet_size_in_bytes <= PKT_BYTES_W'(cnt_n) * BPW;
                    end else if (accept) begin
                        state <= S_LOAD;
                    end
                end
                S_SEND: begin
                    if (!o_tanswer_ready) begin
                        // word 0 read is in flight this cycle
                        o_tanswer_ready     <= 1'b1;
                        o_tanswer_data_last <= (wr_cnt == 1);
                        rd_idx              <= '0;
                    end else if (xfer) begin
                        if (o_tanswer_data_last) begin
                            state                  <= S_IDLE;
                            wr_cnt                 <= '0;
                            target                 <= '0;
                            rd_idx                 <= '0;
                            o_tanswer_ready        <= 1'b0;
                            o_tanswer_data_last    <= 1'b0;
                            o_packet_size_in_bytes <= '0;
                            o_busy                 <= 1'b0;
                            o_full                 <= 1'b0;
                        end else begin
                            rd_idx              <= rd_nxt;
                            o_tanswer_data_last <= (rd_nxt == wr_cnt - 1'b1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_task_pkt_out.sv
// Directed bench for task_pkt_out: an 8-bit and a 16-bit instance share stimulus;
// most checks look at the 8-bit one, the full-buffer case at the 16-bit one.
module tb_task_pkt_out;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [15:0] i_data;
    logic        i_data_valid;
    logic        i_input_last;
    logic [7:0]  i_pkt_words;
    logic        i_tmanager_ready;

    logic        tr8, tl8, bz8, fl8, ov8;
    logic [7:0]  td8;
    logic [11:0] sz8;
    logic        tr16, tl16, bz16, fl16, ov16;
    logic [15:0] td16;
    logic [11:0] sz16;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] bd[$];
    logic       bl[$];
    int         holdbad;
    bit         done;

    always #5 i_clk = ~i_clk;

    task_pkt_out #(.DATA_WIDTH(8), .MAX_WORDS(128)) u_d8 (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data[7:0]), .i_data_valid(i_data_valid),
        .i_input_last(i_input_last), .i_pkt_words(i_pkt_words), .i_tmanager_ready(i_tmanager_ready),
        .o_tanswer_ready(tr8), .o_tdata(td8), .o_tanswer_data_last(tl8),
        .o_packet_size_in_bytes(sz8), .o_busy(bz8), .o_full(fl8), .o_overflow(ov8)
    );

    task_pkt_out #(.DATA_WIDTH(16), .MAX_WORDS(128)) u_d16 (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_data_valid(i_data_valid),
        .i_input_last(i_input_last), .i_pkt_words(i_pkt_words), .i_tmanager_ready(i_tmanager_ready),
        .o_tanswer_ready(tr16), .o_tdata(td16), .o_tanswer_data_last(tl16),
        .o_packet_size_in_bytes(sz16), .o_busy(bz16), .o_full(fl16), .o_overflow(ov16)
    );

    task step;
        @(posedge i_clk);
        #1;
    endtask

    task load(input logic [7:0] pw, input logic [7:0] first, input int n, input bit last_on_end);
        i_pkt_words = pw;
        for (int i = 0; i < n; i++) begin
            i_data_valid = 1'b1;
            i_data       = 16'(first) + 16'(i);
            i_input_last = last_on_end && (i == n - 1);
            step();
        end
        i_data_valid = 1'b0;
        i_input_last = 1'b0;
    endtask

    // Drains the 8-bit instance; toggle selects ready pattern 1,0,0,1,0,0,...
    task run_out(input int maxc, input bit toggle);
        bit   pst;
        logic [7:0] pd;
        logic pl;
        bd.delete();
        bl.delete();
        holdbad = 0;
        done    = 1'b0;
        pst     = 1'b0;
        pd      = '0;
        pl      = 1'b0;
        for (int c = 0; c < maxc; c++) begin
            i_tmanager_ready = toggle ? (c % 3 == 0) : 1'b1;
            if (pst && (td8 !== pd || tl8 !== pl)) holdbad++;
            pst = tr8 && !i_tmanager_ready;
            pd  = td8;
            pl  = tl8;
            if (tr8 && i_tmanager_ready) begin
                bd.push_back(td8);
                bl.push_back(tl8);
                if (tl8) begin
                    step();
                    done = 1'b1;
                    break;
                end
            end
            step();
        end
        i_tmanager_ready = 1'b0;
    endtask

    task test_reset;
        i_rst = 1'b1;
        step();
        step();
        n_cmp++;
        if ({tr8, td8, tl8, sz8, bz8, fl8, ov8} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got tr=%0b td=%h tl=%0b sz=%0d bz=%0b fl=%0b ov=%0b want all 0",
                     tr8, td8, tl8, sz8, bz8, fl8, ov8);
        end
        i_rst = 1'b0;
    endtask

    task test_basic;
        load(8'd5, 8'h11, 5, 1'b0);
        n_cmp++;
        if (bz8 !== 1'b1 || sz8 !== 12'd5) begin
            n_bad++;
            $display("FAIL basic_busy_size got bz=%0b sz=%0d want bz=1 sz=5", bz8, sz8);
        end
        run_out(30, 1'b0);
        n_cmp++;
        if (!done || bd.size() != 5) begin
            n_bad++;
            $display("FAIL basic_beats got %0d beats done=%0b want 5 done=1", bd.size(), done);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (bd[i] !== 8'(8'h11 + i) || bl[i] !== (i == 4)) begin
                    n_bad++;
                    $display("FAIL basic_beat%0d got %h/%0b want %h/%0b", i, bd[i], bl[i], 8'(8'h11 + i), (i == 4));
                end
            end
        end
        n_cmp++;
        if (tr8 !== 1'b0 || bz8 !== 1'b0 || sz8 !== 12'd0) begin
            n_bad++;
            $display("FAIL basic_idle_after got tr=%0b bz=%0b sz=%0d want 0 0 0", tr8, bz8, sz8);
        end
    endtask

    task test_early_last;
        load(8'd10, 8'h21, 3, 1'b1);
        n_cmp++;
        if (bz8 !== 1'b1 || sz8 !== 12'd3) begin
            n_bad++;
            $display("FAIL early_size got bz=%0b sz=%0d want bz=1 sz=3", bz8, sz8);
        end
        run_out(30, 1'b0);
        n_cmp++;
        if (!done || bd.size() != 3 || bd[0] !== 8'h21 || bd[1] !== 8'h22 || bd[2] !== 8'h23 ||
            bl[0] !== 1'b0 || bl[1] !== 1'b0 || bl[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL early_beats got n=%0d want 21,22,23 with last on 3rd", bd.size());
        end
    endtask

    task test_idle_last;
        i_input_last = 1'b1;
        step();
        i_input_last = 1'b0;
        step();
        n_cmp++;
        if (bz8 !== 1'b0 || tr8 !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_last got bz=%0b tr=%0b want 0 0", bz8, tr8);
        end
    endtask

    task test_stall;
        load(8'd4, 8'h31, 4, 1'b0);
        run_out(60, 1'b1);
        n_cmp++;
        if (holdbad != 0) begin
            n_bad++;
            $display("FAIL stall_hold got %0d changes during stall want 0", holdbad);
        end
        n_cmp++;
        if (!done || bd.size() != 4 || bd[0] !== 8'h31 || bd[1] !== 8'h32 || bd[2] !== 8'h33 ||
            bd[3] !== 8'h34 || bl[2] !== 1'b0 || bl[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_beats got n=%0d want 31,32,33,34 last on 4th", bd.size());
        end
    endtask

    task test_overflow;
        load(8'd2, 8'h41, 2, 1'b0);
        for (int k = 0; k < 2; k++) begin
            i_data_valid = 1'b1;
            i_data       = 16'h0099 - 16'(k);
            step();
            i_data_valid = 1'b0;
            n_cmp++;
            if (ov8 !== 1'b1) begin
                n_bad++;
                $display("FAIL ovf_pulse%0d got %0b want 1", k, ov8);
            end
            step();
            n_cmp++;
            if (ov8 !== 1'b0) begin
                n_bad++;
                $display("FAIL ovf_clear%0d got %0b want 0", k, ov8);
            end
        end
        run_out(30, 1'b0);
        n_cmp++;
        if (!done || bd.size() != 2 || bd[0] !== 8'h41 || bd[1] !== 8'h42 || bl[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_beats got n=%0d want 41,42 only", bd.size());
        end
    endtask

    task test_full;
        bit early = 1'b0;
        int k = 0;
        int dbad = 0;
        bit fin = 1'b0;
        i_pkt_words = 8'd0;
        for (int i = 0; i < 128; i++) begin
            if (bz16) early = 1'b1;
            i_data_valid = 1'b1;
            i_data       = 16'h1000 + 16'(i);
            step();
        end
        i_data_valid = 1'b0;
        n_cmp++;
        if (early || bz16 !== 1'b1 || fl16 !== 1'b1) begin
            n_bad++;
            $display("FAIL full_close got early=%0b bz=%0b full=%0b want 0 1 1", early, bz16, fl16);
        end
        n_cmp++;
        if (sz16 !== 12'd256 || sz8 !== 12'd128) begin
            n_bad++;
            $display("FAIL full_size got sz16=%0d sz8=%0d want 256 128", sz16, sz8);
        end
        i_tmanager_ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (tr16) begin
                if (td16 !== 16'h1000 + 16'(k)) dbad++;
                k++;
                if (tl16) begin
                    step();
                    fin = 1'b1;
                    break;
                end
            end
            step();
        end
        i_tmanager_ready = 1'b0;
        n_cmp++;
        if (!fin || k != 128 || dbad != 0 || bz16 !== 1'b0 || fl16 !== 1'b0) begin
            n_bad++;
            $display("FAIL full_drain got beats=%0d bad=%0d fin=%0b bz=%0b fl=%0b want 128 0 1 0 0",
                     k, dbad, fin, bz16, fl16);
        end
    endtask

    task test_reset_mid;
        bit lseen = 1'b0;
        load(8'd6, 8'h51, 6, 1'b0);
        i_tmanager_ready = 1'b1;
        step();
        lseen |= tl8;
        n_cmp++;
        if (tr8 !== 1'b1 || td8 !== 8'h51) begin
            n_bad++;
            $display("FAIL rmid_first got tr=%0b td=%h want 1 51", tr8, td8);
        end
        step();
        lseen |= tl8;
        step();
        lseen |= tl8;
        i_tmanager_ready = 1'b0;
        i_rst = 1'b1;
        step();
        n_cmp++;
        if ({tr8, td8, tl8, sz8, bz8, fl8, ov8} !== '0 || lseen) begin
            n_bad++;
            $display("FAIL rmid_outputs got tr=%0b td=%h tl=%0b sz=%0d bz=%0b lseen=%0b want all 0",
                     tr8, td8, tl8, sz8, bz8, lseen);
        end
        i_rst = 1'b0;
        load(8'd2, 8'h61, 2, 1'b0);
        run_out(30, 1'b0);
        n_cmp++;
        if (!done || bd.size() != 2 || bd[0] !== 8'h61 || bd[1] !== 8'h62 ||
            bl[0] !== 1'b0 || bl[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_new_pkt got n=%0d want 61,62 last on 2nd", bd.size());
        end
    endtask

    initial begin
        i_rst            = 1'b1;
        i_data           = '0;
        i_data_valid     = 1'b0;
        i_input_last     = 1'b0;
        i_pkt_words      = '0;
        i_tmanager_ready = 1'b0;
        test_reset();
        test_basic();
        test_early_last();
        test_idle_last();
        test_stall();
        test_overflow();
        test_full();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/task_pkt_out.md
TASK_PKT_OUT -- requirements
Module: task_pkt_out

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter MAX_WORDS, default 128, packet buffer depth in words; MAX_WORDS*DATA_WIDTH/8 SHALL be <= 4095.
REQ-003 Parameter CNT_W, default $clog2(MAX_WORDS+1), word-counter width.
REQ-004 i_clk  in  1  single clock; all logic on rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_data  in  DATA_WIDTH  input word.
REQ-007 i_data_valid  in  1  input word strobe.
REQ-008 i_input_last  in  1  closes the current packet early.
REQ-009 i_pkt_words  in  CNT_W  target packet length in words.
REQ-010 i_tmanager_ready  in  1  downstream ready.
REQ-011 o_tanswer_ready  out  1  output word valid.
REQ-012 o_tdata  out  DATA_WIDTH  output word.
REQ-013 o_tanswer_data_last  out  1  marks the final beat of the packet.
REQ-014 o_packet_size_in_bytes  out  12  byte count of the packet being sent.
REQ-015 o_busy  out  1  high while sending; input is not accepted.
REQ-016 o_full  out  1  buffer holds MAX_WORDS words.
REQ-017 o_overflow  out  1  one-cycle pulse when an input word is dropped.

Function
REQ-018 States SHALL be S_IDLE (empty), S_LOAD (1..MAX_WORDS-1 words held) and S_SEND.
REQ-019 Target length SHALL be sampled when the first word of a packet is accepted: 0 or >MAX_WORDS maps to MAX_WORDS; otherwise the value is used as-is.
REQ-020 Target length SHALL be held constant for the rest of the packet.
REQ-021 In S_IDLE/S_LOAD, each i_data_valid word SHALL be written at the write index, and the index SHALL increment.
REQ-022 The packet SHALL close when the accepted count reaches the target, or on i_input_last with count>=1 after that cycle's write.
REQ-023 A word arriving with i_input_last in the same cycle SHALL be included in the packet.
REQ-024 i_input_last with count 0 and no valid word SHALL be ignored; the block stays in S_IDLE and no packet is produced.
REQ-025 On close, the next state SHALL be S_SEND.
REQ-026 o_busy SHALL be 1 and o_packet_size_in_bytes SHALL be count*DATA_WIDTH/8, both registered and stable for the whole of S_SEND.
REQ-027 o_packet_size_in_bytes SHALL be 0 outside S_SEND.
REQ-028 o_tanswer_ready SHALL assert one cycle after entry to S_SEND, presenting word 0.
REQ-029 A beat SHALL transfer on a cycle with o_tanswer_ready and i_tmanager_ready both high.
REQ-030 o_tdata and o_tanswer_data_last SHALL hold stable while o_tanswer_ready=1 and i_tmanager_ready=0.
REQ-031 After each transfer, the next word SHALL be presented in the following cycle, with no bubble.
REQ-032 o_tanswer_data_last SHALL be 1 exactly on the beat with index count-1.
REQ-033 A one-word packet SHALL have o_tanswer_data_last set on its first beat.
REQ-034 On transfer of the last beat, the block SHALL return to S_IDLE next cycle, with valid, busy, size and counters cleared.
REQ-035 i_data_valid during S_SEND SHALL drop the word and pulse o_overflow the next cycle.
REQ-036 o_full SHALL be 1 when count==MAX_WORDS; this state is transient because reaching the target forces S_SEND.
REQ-037 Counters SHALL never wrap: write count saturates at the target and read index at count-1.

Reset
REQ-038 When i_rst=1 at a rising edge, the state SHALL become S_IDLE, counters 0, and the buffer contents SHALL be discarded.
REQ-039 On that reset, all outputs SHALL become 0: o_tdata 0, o_tanswer_ready 0, o_tanswer_data_last 0, size 0, o_busy 0, o_full 0, o_overflow 0.
REQ-040 Reset mid-packet, in S_LOAD or S_SEND, SHALL abort without emitting o_tanswer_data_last.
REQ-041 The first cycle after reset SHALL accept input.

Structure
REQ-042 Package task_pkt_pkg SHALL hold the state enum (S_IDLE, S_LOAD, S_SEND) and a localparam PKT_BYTES_W=12.
REQ-043 Storage SHALL be one sub-module task_pkt_buf: a simple dual-port RAM, DATA_WIDTH x MAX_WORDS, synchronous write, 1-cycle registered read, with no vendor FIFO primitive.
REQ-044 The FSM, counters and output registers SHALL reside in task_pkt_out.

Verification
REQ-045 Bench SHALL cover: i_pkt_words=5, words 0x11..0x15 back-to-back, ready=1 -> busy high; size=5; five beats 0x11..0x15; last on 0x15; idle 1 cycle after.
REQ-046 Bench SHALL cover: i_pkt_words=10, 3 words, last with 3rd -> size=3; 3 beats; last on beat 3.
REQ-047 Bench SHALL cover: packet of 4, ready toggling 1,0,0,1,... -> tdata/last held during stalls; exactly 4 transfers; order preserved.
REQ-048 Bench SHALL cover: valid during S_SEND -> word absent from output; o_overflow one pulse per dropped word.
REQ-049 Bench SHALL cover: i_pkt_words=0, DATA_WIDTH=16, MAX_WORDS=128 -> closes at 128 words; o_full seen; size=256.
REQ-050 Bench SHALL cover: i_rst after the 2nd beat of a 6-word packet -> all outputs 0 next cycle; no last; a new 2-word packet sends correctly.
